// File: rtl/alloc_pkg.sv
// -----------------------------------------------------------------------------
// alloc_pkg
// Shared definitions for the allocator arbiter, the allocator and the test
// fixture: op encodings, FSM state encoding and a small wrap helper.
// -----------------------------------------------------------------------------
package alloc_pkg;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_FREE  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Increment an index modulo n (n-1 wraps to 0).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/alloc_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first requester with its
// request bit set, scanning ptr_i, ptr_i+1, ... modulo N_REQ.
//   req_i  : request vector
//   ptr_i  : index with the highest priority this round
//   idx_o  : chosen requester (0 when nothing is requested)
//   any_o  : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int cand;

   always_comb begin
      idx_o = '0;
      cand  = 0;
      any_o = |req_i;
      // Scan from the farthest offset back to ptr_i so the nearest set
      // requester is the last (and therefore winning) assignment.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = (int'(ptr_i) + k) % N_REQ;
         if (req_i[cand]) idx_o = IDX_W'(cand);
      end
   end

endmodule

// File: rtl/alloc_arbiter.sv
// -----------------------------------------------------------------------------
// alloc_arbiter
// Shares one cell allocator between N_REQ requesters. Round-robin grant, one
// transaction in flight, watchdog on the allocator acknowledge.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_en                    : allow new grants
//   i_req/i_op/i_data/i_addr: per-requester request, op, alloc payload, free addr
//   o_ack                   : one-hot completion pulse
//   o_addr/o_err            : result, valid in the o_ack cycle, held afterwards
//   o_busy/o_timeout        : FSM not idle / sticky timeout flag
//   o_mem_*, i_mem_*        : allocator request/response port
// -----------------------------------------------------------------------------
module alloc_arbiter
   import alloc_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_SZ = 32,
   parameter int ADDR_SZ = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ-1:0]         i_op,
   input  logic [N_REQ*DATA_SZ-1:0] i_data,
   input  logic [N_REQ*ADDR_SZ-1:0] i_addr,
   output logic [N_REQ-1:0]         o_ack,
   output logic [ADDR_SZ-1:0]       o_addr,
   output logic                     o_err,
   output logic                     o_busy,
   output logic                     o_timeout,
   output logic                     o_mem_req,
   output logic                     o_mem_op,
   output logic [DATA_SZ-1:0]       o_mem_data,
   output logic [ADDR_SZ-1:0]       o_mem_addr,
   input  logic                     i_mem_ack,
   input  logic [ADDR_SZ-1:0]       i_mem_addr,
   input  logic                     i_mem_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, gnt_q, pick_idx;
   logic [CNT_W-1:0]   cnt_q;
   logic               any_req, grant, expire;
   logic               mem_req_q, mem_op_q, err_q, timeout_q;
   logic [DATA_SZ-1:0] mem_data_q;
   logic [ADDR_SZ-1:0] mem_addr_q, addr_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i (i_req),
      .ptr_i (rr_ptr_q),
      .idx_o (pick_idx),
      .any_o (any_req)
   );

   assign grant  = i_en & any_req;
   // Counter starts at 0 in the first ISSUE cycle, so TIMEOUT-1 marks the
   // last cycle o_mem_req is allowed to stay high.
   assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a same-cycle ack beats expiry only in the datapath,
   // both lead to DONE here.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant) state_d = ST_ISSUE;
         ST_ISSUE: if (i_mem_ack || expire) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      o_ack  = '0;
      o_busy = (state_q != ST_IDLE);
      if (state_q == ST_DONE) o_ack[gnt_q] = 1'b1;
   end

   // Transaction latches, counter, results and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         cnt_q      <= '0;
         mem_req_q  <= 1'b0;
         mem_op_q   <= 1'b0;
         mem_data_q <= '0;
         mem_addr_q <= '0;
         addr_q     <= '0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  gnt_q      <= pick_idx;
                  mem_op_q   <= i_op[pick_idx];
                  mem_data_q <= i_data[int'(pick_idx)*DATA_SZ +: DATA_SZ];
                  mem_addr_q <= i_addr[int'(pick_idx)*ADDR_SZ +: ADDR_SZ];
                  cnt_q      <= '0;
                  mem_req_q  <= 1'b1;
               end
            end
            ST_ISSUE: begin
               cnt_q <= cnt_q + 1'b1;
               if (i_mem_ack) begin
                  addr_q    <= i_mem_addr;
                  err_q     <= i_mem_err;
                  mem_req_q <= 1'b0;
               end else if (expire) begin
                  addr_q    <= '0;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
                  mem_req_q <= 1'b0;
               end
            end
            ST_DONE: rr_ptr_q <= IDX_W'(wrap_inc(int'(gnt_q), N_REQ));
            default: ;
         endcase
      end
   end

   assign o_addr     = addr_q;
   assign o_err      = err_q;
   assign o_timeout  = timeout_q;
   assign o_mem_req  = mem_req_q;
   assign o_mem_op   = mem_op_q;
   assign o_mem_data = mem_data_q;
   assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_alloc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alloc_arbiter
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbiter (grant order, latency, results).
// -----------------------------------------------------------------------------
module tb_alloc_arbiter;
   import alloc_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int TO = 16;

   logic            clk;
   logic            rst, en;
   logic [N-1:0]    req, op;
   logic [N*DW-1:0] data;
   logic [N*AW-1:0] addr;
   logic [N-1:0]    ack;
   logic [AW-1:0]   oaddr;
   logic            err, busy, tmo, mreq, mop;
   logic [DW-1:0]   mdata;
   logic [AW-1:0]   maddr_o;
   logic            mack, merr;
   logic [AW-1:0]   mack_addr;

   int n_cmp = 0;
   int n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alloc_arbiter #(.N_REQ(N), .DATA_SZ(DW), .ADDR_SZ(AW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_op(op),
      .i_data(data), .i_addr(addr), .o_ack(ack), .o_addr(oaddr), .o_err(err),
      .o_busy(busy), .o_timeout(tmo), .o_mem_req(mreq), .o_mem_op(mop),
      .o_mem_data(mdata), .o_mem_addr(maddr_o), .i_mem_ack(mack),
      .i_mem_addr(mack_addr), .i_mem_err(merr)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b1; req = '0; op = '0; data = '0; addr = '0;
      mack = 1'b0; merr = 1'b0; mack_addr = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic load_req(input int r, input bit p, input bit o,
                           input logic [DW-1:0] d, input logic [AW-1:0] a);
      req[r] = p; op[r] = o; data[r*DW +: DW] = d; addr[r*AW +: AW] = a;
   endtask

   task automatic wait_mreq(output bit ok);
      int n = 0;
      while (mreq !== 1'b1 && n < 8) begin tick(); n++; end
      ok = (mreq === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      req = '1; mack = 1'b1;
      tick(); tick();
      n_cmp++; if ({ack, oaddr, err, busy, tmo} !== '0) begin n_bad++;
         $display("FAIL reset_status: got %0h want 0", {ack, oaddr, err, busy, tmo}); end
      n_cmp++; if ({mreq, mop, mdata, maddr_o} !== '0) begin n_bad++;
         $display("FAIL reset_mem: got %0h want 0", {mreq, mop, mdata, maddr_o}); end
      req = '0; mack = 1'b0; rst = 1'b0;
      tick(); tick();
      n_cmp++; if ({busy, mreq} !== 2'b00) begin n_bad++;
         $display("FAIL reset_idle: busy/mreq got %b want 00", {busy, mreq}); end
   endtask

   task automatic test_single_alloc();
      bit ok;
      do_reset();
      load_req(0, 1'b1, OP_ALLOC, 32'h0000_00AB, 8'h00);
      wait_mreq(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_req: o_mem_req got 0 want 1"); end
      n_cmp++; if ({mop, mdata} !== {OP_ALLOC, 32'h0000_00AB}) begin n_bad++;
         $display("FAIL single_latch: op/data got %0h want %0h", {mop, mdata}, {OP_ALLOC, 32'h0000_00AB}); end
      tick(); tick();
      mack = 1'b1; mack_addr = 8'h05;
      tick();
      mack = 1'b0; mack_addr = '0;
      n_cmp++; if ({ack, oaddr, err} !== {4'b0001, 8'h05, 1'b0}) begin n_bad++;
         $display("FAIL single_done: ack/addr/err got %0h want %0h", {ack, oaddr, err}, {4'b0001, 8'h05, 1'b0}); end
      req[0] = 1'b0;
      tick();
      n_cmp++; if ({ack, oaddr} !== {4'b0000, 8'h05}) begin n_bad++;
         $display("FAIL single_after: ack/addr got %0h want %0h", {ack, oaddr}, {4'b0000, 8'h05}); end
   endtask

   task automatic test_round_robin();
      int seen[$];
      int t_at[$];
      do_reset();
      for (int r = 0; r < N; r++) load_req(r, 1'b1, OP_ALLOC, DW'(r + 1), '0);
      mack = 1'b1; mack_addr = 8'h10;
      for (int c = 0; c < 24 && seen.size() < 5; c++) begin
         tick();
         if (ack !== '0) begin seen.push_back(int'(ack)); t_at.push_back(c); end
      end
      mack = 1'b0; req = '0;
      n_cmp++; if (seen.size() != 5) begin n_bad++;
         $display("FAIL rr_count: acks got %0d want 5", seen.size()); end
      for (int i = 0; i < seen.size(); i++) begin
         n_cmp++; if (seen[i] != (1 << (i % N))) begin n_bad++;
            $display("FAIL rr_order[%0d]: ack got %0h want %0h", i, seen[i], 1 << (i % N)); end
         if (i > 0) begin
            n_cmp++; if (t_at[i] - t_at[i-1] != 3) begin n_bad++;
               $display("FAIL rr_spacing[%0d]: got %0d want 3", i, t_at[i] - t_at[i-1]); end
         end
      end
   endtask

   task automatic test_free_err();
      bit ok;
      do_reset();
      load_req(2, 1'b1, OP_FREE, 32'h5555_AAAA, 8'h3F);
      wait_mreq(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL free_req: o_mem_req got 0 want 1"); end
      // Inputs move after the grant; the latched transaction must not.
      load_req(2, 1'b0, OP_ALLOC, 32'h0, 8'h00);
      tick();
      n_cmp++; if ({mop, maddr_o} !== {OP_FREE, 8'h3F}) begin n_bad++;
         $display("FAIL free_latch: op/addr got %0h want %0h", {mop, maddr_o}, {OP_FREE, 8'h3F}); end
      mack = 1'b1; merr = 1'b1; mack_addr = 8'h3F;
      tick();
      mack = 1'b0; merr = 1'b0; mack_addr = '0;
      n_cmp++; if ({ack, err, oaddr} !== {4'b0100, 1'b1, 8'h3F}) begin n_bad++;
         $display("FAIL free_done: ack/err/addr got %0h want %0h", {ack, err, oaddr}, {4'b0100, 1'b1, 8'h3F}); end
      tick();
   endtask

   task automatic test_timeout();
      bit ok;
      int hi;
      tick();
      load_req(1, 1'b1, OP_ALLOC, 32'h1111_0001, 8'h00);
      wait_mreq(ok);
      hi = ok ? 1 : 0;
      while (mreq === 1'b1 && hi < 40) begin tick(); if (mreq === 1'b1) hi++; end
      n_cmp++; if (hi != TO) begin n_bad++;
         $display("FAIL timeout_len: o_mem_req high got %0d want %0d", hi, TO); end
      n_cmp++; if ({ack, err, oaddr, tmo} !== {4'b0010, 1'b1, 8'h00, 1'b1}) begin n_bad++;
         $display("FAIL timeout_done: ack/err/addr/tmo got %0h want %0h", {ack, err, oaddr, tmo}, {4'b0010, 1'b1, 8'h00, 1'b1}); end
      req[1] = 1'b0;
      mack = 1'b1; mack_addr = 8'hEE;
      tick(); tick();
      mack = 1'b0; mack_addr = '0;
      n_cmp++; if ({tmo, oaddr, busy} !== {1'b1, 8'h00, 1'b0}) begin n_bad++;
         $display("FAIL timeout_sticky: tmo/addr/busy got %0h want %0h", {tmo, oaddr, busy}, {1'b1, 8'h00, 1'b0}); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      load_req(2, 1'b1, OP_ALLOC, 32'h0000_0022, 8'h00);
      wait_mreq(ok);
      n_cmp++; if (mdata !== 32'h0000_0022) begin n_bad++;
         $display("FAIL rstmid_pre: data got %0h want 22", mdata); end
      tick(); tick();
      rst = 1'b1;
      tick();
      n_cmp++; if ({ack, oaddr, err, busy, tmo, mreq, mop, mdata, maddr_o} !== '0) begin n_bad++;
         $display("FAIL rstmid_clear: outputs got %0h want 0", {ack, oaddr, err, busy, tmo, mreq, mop, mdata, maddr_o}); end
      rst = 1'b0;
      load_req(0, 1'b1, OP_ALLOC, 32'h1234_5678, 8'h00);
      tick();
      n_cmp++; if ({mreq, mdata} !== {1'b1, 32'h1234_5678}) begin n_bad++;
         $display("FAIL rstmid_regrant: req/data got %0h want %0h", {mreq, mdata}, {1'b1, 32'h1234_5678}); end
      mack = 1'b1;
      tick();
      mack = 1'b0; req = '0;
      n_cmp++; if (ack !== 4'b0001) begin n_bad++;
         $display("FAIL rstmid_ack: ack got %b want 0001", ack); end
      tick();
   endtask

   task automatic test_en_gating();
      int stray = 0;
      do_reset();
      en = 1'b0;
      load_req(3, 1'b1, OP_ALLOC, 32'hDEAD_0003, 8'h00);
      for (int c = 0; c < 10; c++) begin tick(); if (mreq !== 1'b0 || busy !== 1'b0) stray++; end
      n_cmp++; if (stray != 0) begin n_bad++;
         $display("FAIL en_gate: active cycles got %0d want 0", stray); end
      en = 1'b1;
      tick();
      n_cmp++; if ({mreq, mdata} !== {1'b1, 32'hDEAD_0003}) begin n_bad++;
         $display("FAIL en_rise: req/data got %0h want %0h", {mreq, mdata}, {1'b1, 32'hDEAD_0003}); end
      en = 1'b0;
      tick();
      mack = 1'b1; mack_addr = 8'h77;
      tick();
      mack = 1'b0; mack_addr = '0;
      n_cmp++; if ({ack, oaddr} !== {4'b1000, 8'h77}) begin n_bad++;
         $display("FAIL en_fall_done: ack/addr got %0h want %0h", {ack, oaddr}, {4'b1000, 8'h77}); end
      stray = 0;
      for (int c = 0; c < 5; c++) begin tick(); if (busy !== 1'b0 || mreq !== 1'b0) stray++; end
      n_cmp++; if (stray != 0) begin n_bad++;
         $display("FAIL en_fall_idle: busy cycles got %0d want 0", stray); end
      req = '0; en = 1'b1;
   endtask

   task automatic test_random();
      int ptr;
      bit [N-1:0] pend;
      bit pop [N];
      logic [DW-1:0] pdat [N];
      logic [AW-1:0] padr [N];
      bit exp_tmo, exp_err;
      logic [AW-1:0] exp_addr;
      do_reset();
      ptr = 0; exp_tmo = 1'b0;
      for (int r = 0; r < N; r++) begin
         pend[r] = 1'($urandom); pop[r] = 1'($urandom);
         pdat[r] = $urandom; padr[r] = AW'($urandom);
      end
      if (pend == '0) pend[0] = 1'b1;
      for (int r = 0; r < N; r++) load_req(r, pend[r], pop[r], pdat[r], padr[r]);
      for (int t = 0; t < 60; t++) begin
         int g, lat, hi, exp_hi;
         bit ok, re;
         logic [AW-1:0] ra;
         // Expected winner: nearest pending requester at or after the pointer.
         g = -1;
         for (int k = 0; k < N; k++) if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
         wait_mreq(ok);
         n_cmp++; if (!ok) begin n_bad++;
            $display("FAIL rnd_start[%0d]: o_mem_req got 0 want 1", t); return; end
         n_cmp++; if ({mop, mdata, maddr_o} !== {pop[g], pdat[g], padr[g]}) begin n_bad++;
            $display("FAIL rnd_latch[%0d]: got %0h want %0h (r%0d)", t, {mop, mdata, maddr_o}, {pop[g], pdat[g], padr[g]}, g); end
         if ($urandom_range(0, 1) == 1) begin
            load_req(g, 1'($urandom), ~pop[g], $urandom, AW'($urandom));
         end
         case ($urandom_range(0, 7))
            0, 1, 2, 3: lat = $urandom_range(0, 3);
            4:          lat = TO - 2;
            5:          lat = TO - 1;
            6:          lat = TO;
            default:    lat = TO + 1;
         endcase
         ra = AW'($urandom); re = 1'($urandom);
         hi = 0;
         while (mreq === 1'b1 && hi < TO + 4) begin
            if (hi == lat) begin mack = 1'b1; mack_addr = ra; merr = re; end
            hi++;
            tick();
            mack = 1'b0; merr = 1'b0; mack_addr = '0;
         end
         if (lat < TO) begin exp_hi = lat + 1; exp_addr = ra; exp_err = re; end
         else begin exp_hi = TO; exp_addr = '0; exp_err = 1'b1; exp_tmo = 1'b1; end
         n_cmp++; if (hi != exp_hi) begin n_bad++;
            $display("FAIL rnd_len[%0d]: o_mem_req cycles got %0d want %0d", t, hi, exp_hi); end
         n_cmp++; if ({ack, oaddr, err, tmo} !== {N'(1) << g, exp_addr, exp_err, exp_tmo}) begin n_bad++;
            $display("FAIL rnd_done[%0d]: ack/addr/err/tmo got %0h want %0h", t, {ack, oaddr, err, tmo}, {N'(1) << g, exp_addr, exp_err, exp_tmo}); end
         n_cmp++; if ({mop, mdata, maddr_o} !== {pop[g], pdat[g], padr[g]}) begin n_bad++;
            $display("FAIL rnd_hold[%0d]: got %0h want %0h", t, {mop, mdata, maddr_o}, {pop[g], pdat[g], padr[g]}); end
         // Completed requester may issue a fresh request; others stay held.
         pend[g] = 1'($urandom); pop[g] = 1'($urandom);
         pdat[g] = $urandom; padr[g] = AW'($urandom);
         if (pend == '0) pend[(g + 1) % N] = 1'b1;
         for (int r = 0; r < N; r++) load_req(r, pend[r], pop[r], pdat[r], padr[r]);
         ptr = (g + 1) % N;
         if ($urandom_range(0, 1) == 1) begin
            mack = 1'b1; mack_addr = ~exp_addr; merr = ~exp_err;
         end
         tick();
         mack = 1'b0; merr = 1'b0; mack_addr = '0;
         n_cmp++; if ({ack, oaddr, err} !== {N'(0), exp_addr, exp_err}) begin n_bad++;
            $display("FAIL rnd_idle[%0d]: ack/addr/err got %0h want %0h", t, {ack, oaddr, err}, {N'(0), exp_addr, exp_err}); end
      end
      req = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_alloc();
      test_round_robin();
      test_free_err();
      test_timeout();
      test_reset_mid();
      test_en_gating();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alloc_arbiter.md
Name: alloc_arbiter

Overview:
- Shares one cell allocator (alloc/free port) between N_REQ independent requesters.
- Round-robin grant, one transaction in flight at a time.
- Per-requester request/acknowledge handshake; watchdog timeout on the allocator side.
- Sits between client engines (e.g. an actor dispatcher and a GC sweeper) and the allocator; the existing test fixture drives it through i_en.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_SZ, 32: cell data width written on alloc.
- ADDR_SZ, 8: cell address width.
- TIMEOUT, 16: max cycles waiting for i_mem_ack before forced completion (>=2).

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  grant enable; when low no new grant is issued, but an in-flight transaction still completes.
- i_req  in  N_REQ  per-requester request; held high until the matching o_ack.
- i_op  in  N_REQ  per-requester op: 0=alloc, 1=free.
- i_data  in  N_REQ*DATA_SZ  alloc payload; requester r occupies bits [r*DATA_SZ +: DATA_SZ].
- i_addr  in  N_REQ*ADDR_SZ  free target; requester r occupies bits [r*ADDR_SZ +: ADDR_SZ].
- o_ack  out  N_REQ  one-hot, one-cycle completion pulse.
- o_addr  out  ADDR_SZ  allocated address; valid in the o_ack cycle.
- o_err  out  1  allocator error or timeout; valid in the o_ack cycle.
- o_busy  out  1  high while the FSM is not in IDLE.
- o_timeout  out  1  sticky; set on any timeout, cleared only by i_rst.
- o_mem_req  out  1  request to the allocator.
- o_mem_op  out  1  latched op.
- o_mem_data  out  DATA_SZ  latched payload.
- o_mem_addr  out  ADDR_SZ  latched free address.
- i_mem_ack  in  1  allocator completion.
- i_mem_addr  in  ADDR_SZ  allocator result address.
- i_mem_err  in  1  allocator error (out of memory, or free of an invalid cell).

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0.
- Reset mid-transaction: o_mem_req drops the next cycle, no o_ack is issued, o_timeout clears.
- State IDLE:
  - If i_en and |i_req, pick g = first requester with i_req set, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Latch i_op[g], i_data[g], i_addr[g] into o_mem_*; latch g; clear the counter; go ISSUE.
- State ISSUE:
  - o_mem_req=1 and o_mem_* held stable; counter increments each cycle.
  - On i_mem_ack (it may arrive in the first ISSUE cycle): register o_addr<=i_mem_addr, o_err<=i_mem_err, o_mem_req<=0; go DONE.
  - For frees, o_addr <= i_mem_addr unchanged.
  - If no ack and the counter reaches TIMEOUT-1: o_mem_req<=0, o_err<=1, o_addr<=0, o_timeout<=1; go DONE.
  - An i_mem_ack in the same cycle as expiry wins (normal completion).
- State DONE:
  - o_ack[g]=1 for exactly one cycle; rr_ptr <= (g+1) mod N_REQ, wrapping at N_REQ-1 -> 0.
  - Go IDLE.
  - o_addr/o_err hold until the next DONE.
- Minimum throughput: 3 cycles per transaction (IDLE, ISSUE, DONE).
- A requester deasserting i_req while in flight is not cancelled; it still receives o_ack.
- i_mem_ack outside ISSUE is ignored.
- i_req/i_op/i_data/i_addr changes after grant have no effect on the latched transaction.
- i_en falling during ISSUE: the transaction completes normally; the FSM stays in IDLE afterwards.
- Starvation bound: any requester held high is granted within N_REQ grants.

Decomposition:
- Package alloc_pkg:
  - OP_ALLOC=1'b0, OP_FREE=1'b1.
  - FSM state encodings ST_IDLE, ST_ISSUE, ST_DONE.
  - Shared with the allocator and test fixture.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: grant index and any_req.
  - Verified standalone.

Test Plan:
- Single alloc: r0 req, op=0, data=32'h0000_00AB; allocator acks 2 cycles later with addr=8'h05 -> o_ack=4'b0001 one cycle, o_addr=8'h05, o_err=0, o_mem_data=32'h0000_00AB.
- Round-robin: all 4 requesters held high, allocator acks immediately -> grant order 0,1,2,3,0; each o_ack 3 cycles apart; wrap from r3 to r0 observed.
- Free with error: r2 frees addr 8'h3F, allocator acks with i_mem_err=1 -> o_ack=4'b0100, o_err=1, o_mem_op=1, o_mem_addr=8'h3F.
- Timeout: r1 requests, allocator never acks -> o_mem_req high exactly 16 cycles then drops, o_ack=4'b0010, o_err=1, o_timeout stays 1 afterward.
- Reset mid-ISSUE: i_rst pulsed 1 cycle while waiting -> no o_ack; next cycle all outputs 0; next grant goes to r0 regardless of prior rr_ptr.
- i_en gating: i_en=0 with r3 requesting for 10 cycles -> o_mem_req stays 0; raising i_en -> o_mem_req asserts 1 cycle later.
